// File: rtl/vga_pkg.sv
// vga_pkg
// Shared timing defaults for the 640x480@60 raster and the colour type that
// img_generator and vga_timing_out exchange.
//   color_t           3-bit {r,g,b} pixel colour
//   VGA_H_* / VGA_V_* default porch, sync and active sizes plus totals
//   VGA_SYNC_ACTIVE   level of an asserted sync pulse (0 = active-low)
package vga_pkg;

  typedef logic [2:0] color_t;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam logic VGA_SYNC_ACTIVE = 1'b0;

  // Level driven on a sync pin for a given "inside the pulse window" flag.
  function automatic logic syncLevel(input logic inWindow, input logic activeLevel);
    return inWindow ? activeLevel : ~activeLevel;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One raster axis (horizontal or vertical). Counts 0..TOTAL-1 while enabled
// and wraps to 0. The outputs describe the value the counter takes at the
// coming clock edge, so the caller can register its flags in the same cycle
// as the count and get them aligned with no skew.
//   i_clk     clock
//   i_enable  advance the count at the next edge
//   i_clear   force the count to TOTAL-1 (so the first enabled edge gives 0)
//   o_count   next count value
//   o_wrap    the count wraps TOTAL-1 -> 0 at the next edge
//   o_active  next count lies in the visible region
//   o_sync    next count lies in the sync pulse window
module vga_axis_counter #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic       i_clk,
  input  logic       i_enable,
  input  logic       i_clear,
  output logic [9:0] o_count,
  output logic       o_wrap,
  output logic       o_active,
  output logic       o_sync
);

  localparam int         TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam logic [9:0] LAST       = 10'(TOTAL - 1);
  localparam logic [9:0] ACTIVE_END = 10'(ACTIVE);
  localparam logic [9:0] SYNC_START = 10'(ACTIVE + FP);
  localparam logic [9:0] SYNC_END   = 10'(ACTIVE + FP + SYNC);

  logic [9:0] r_count;
  logic [9:0] w_next;
  logic       w_atLast;

  assign w_atLast = (r_count == LAST);

  // Clear parks the count on its last value so that the first enabled edge
  // afterwards lands on 0, exactly like a normal wrap.
  always_comb begin
    w_next = r_count;
    if (i_clear) begin
      w_next = LAST;
    end else if (i_enable) begin
      w_next = w_atLast ? 10'd0 : r_count + 10'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    r_count <= w_next;
  end

  assign o_count  = w_next;
  assign o_wrap   = i_enable && !i_clear && w_atLast;
  assign o_active = (w_next < ACTIVE_END);
  assign o_sync   = (w_next >= SYNC_START) && (w_next < SYNC_END);

endmodule

// File: rtl/vga_timing_out.sv
// vga_timing_out
// Frame timing and pin stage around img_generator. Produces the raster
// coordinates and per-frame/per-line ticks, masks img_generator's colour
// outside the visible area and drives the VGA sync and colour pins.
//   CLOCK_25     25 MHz pixel clock
//   RESET        synchronous, active-high reset
//   color_in     colour from img_generator for the current x/y
//   x, y         current pixel position (0..799, 0..524), zero-extended
//   active       x/y inside the visible area
//   frame_start  one-cycle pulse at x=0,y=0
//   line_end     one-cycle pulse at x=799
//   hsync, vsync sync pins
//   rgb          colour pins {r,g,b}
// Build option: define VGA_OUT_REG_EN to add one register stage on
// rgb/hsync/vsync so all pins share a 1-cycle latency relative to x/y.
module vga_timing_out
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE    = VGA_H_ACTIVE,
  parameter int   H_FP        = VGA_H_FP,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BP        = VGA_H_BP,
  parameter int   V_ACTIVE    = VGA_V_ACTIVE,
  parameter int   V_FP        = VGA_V_FP,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BP        = VGA_V_BP,
  parameter logic SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
  input  logic        CLOCK_25,
  input  logic        RESET,
  input  color_t      color_in,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        active,
  output logic        frame_start,
  output logic        line_end,
  output logic        hsync,
  output logic        vsync,
  output color_t      rgb
);

  localparam int         H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int         V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);

  logic [9:0] w_hNext;
  logic       w_hWrap;
  logic       w_hActive;
  logic       w_hSync;
  logic [9:0] w_vNext;
  logic       w_vWrap;
  logic       w_vActive;
  logic       w_vSync;

  logic [11:0] r_x;
  logic [11:0] r_y;
  logic        r_active;
  logic        r_frameStart;
  logic        r_lineEnd;
  logic        r_hsync;
  logic        r_vsync;
  color_t      w_rgbMasked;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_hCounter (
    .i_clk    (CLOCK_25),
    .i_enable (1'b1),
    .i_clear  (RESET),
    .o_count  (w_hNext),
    .o_wrap   (w_hWrap),
    .o_active (w_hActive),
    .o_sync   (w_hSync)
  );

  // The line counter only advances on the pixel counter's wrap, so both
  // wrap in the same cycle at the end of the frame.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_vCounter (
    .i_clk    (CLOCK_25),
    .i_enable (w_hWrap),
    .i_clear  (RESET),
    .o_count  (w_vNext),
    .o_wrap   (w_vWrap),
    .o_active (w_vActive),
    .o_sync   (w_vSync)
  );

  // Coordinates and flags are all registered from the counters' next
  // values, so in any cycle every flag describes the x/y shown with it.
  // A line wrap of the vertical counter only happens when the pixel counter
  // also wraps, which makes it exactly the x=0,y=0 tick.
  always_ff @(posedge CLOCK_25) begin
    if (RESET) begin
      r_x          <= 12'd0;
      r_y          <= 12'd0;
      r_active     <= 1'b0;
      r_frameStart <= 1'b0;
      r_lineEnd    <= 1'b0;
      r_hsync      <= ~SYNC_ACTIVE;
      r_vsync      <= ~SYNC_ACTIVE;
    end else begin
      r_x          <= {2'b00, w_hNext};
      r_y          <= {2'b00, w_vNext};
      r_active     <= w_hActive && w_vActive;
      r_frameStart <= w_vWrap;
      r_lineEnd    <= (w_hNext == H_LAST);
      r_hsync      <= syncLevel(w_hSync, SYNC_ACTIVE);
      r_vsync      <= syncLevel(w_vSync, SYNC_ACTIVE);
    end
  end

  // img_generator is combinational, so its colour belongs to the current
  // x/y and only needs blanking outside the visible area.
  assign w_rgbMasked = r_active ? color_in : 3'b000;

  assign x           = r_x;
  assign y           = r_y;
  assign active      = r_active;
  assign frame_start = r_frameStart;
  assign line_end    = r_lineEnd;

`ifdef VGA_OUT_REG_EN
  logic   r_hsyncPin;
  logic   r_vsyncPin;
  color_t r_rgbPin;

  // Extra pin stage: colour and both syncs are delayed together so the
  // monitor sees them consistently one pixel behind x/y.
  always_ff @(posedge CLOCK_25) begin
    if (RESET) begin
      r_hsyncPin <= ~SYNC_ACTIVE;
      r_vsyncPin <= ~SYNC_ACTIVE;
      r_rgbPin   <= 3'b000;
    end else begin
      r_hsyncPin <= r_hsync;
      r_vsyncPin <= r_vsync;
      r_rgbPin   <= w_rgbMasked;
    end
  end

  assign hsync = r_hsyncPin;
  assign vsync = r_vsyncPin;
  assign rgb   = r_rgbPin;
`else
  assign hsync = r_hsync;
  assign vsync = r_vsync;
  assign rgb   = w_rgbMasked;
`endif

endmodule

// File: tb/tb_vga_timing_out.sv
// tb_vga_timing_out
// Directed bench for vga_timing_out. One instance uses the default
// 640x480 timing; a second instance keeps the horizontal timing but uses an
// 8-line frame (4 active, sync on lines 5..6) so whole-frame behaviour and
// the bottom edge of the visible area can be observed in a short run.
// Honours VGA_OUT_REG_EN by shifting pin expectations one pixel.
module tb_vga_timing_out;

`ifdef VGA_OUT_REG_EN
  localparam int PIN_LAT = 1;
`else
  localparam int PIN_LAT = 0;
`endif

  logic        CLOCK_25;
  logic        RESET;
  logic [2:0]  color_in;

  logic [11:0] x;
  logic [11:0] y;
  logic        active;
  logic        frameStart;
  logic        lineEnd;
  logic        hsync;
  logic        vsync;
  logic [2:0]  rgb;

  logic [11:0] sX;
  logic [11:0] sY;
  logic        sActive;
  logic        sFrameStart;
  logic        sLineEnd;
  logic        sHsync;
  logic        sVsync;
  logic [2:0]  sRgb;

  int vectorCount = 0;
  int missCount   = 0;

  vga_timing_out dut (
    .CLOCK_25    (CLOCK_25),
    .RESET       (RESET),
    .color_in    (color_in),
    .x           (x),
    .y           (y),
    .active      (active),
    .frame_start (frameStart),
    .line_end    (lineEnd),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb)
  );

  vga_timing_out #(
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (2),
    .V_BP     (1)
  ) dutSmall (
    .CLOCK_25    (CLOCK_25),
    .RESET       (RESET),
    .color_in    (color_in),
    .x           (sX),
    .y           (sY),
    .active      (sActive),
    .frame_start (sFrameStart),
    .line_end    (sLineEnd),
    .hsync       (sHsync),
    .vsync       (sVsync),
    .rgb         (sRgb)
  );

  // 25 MHz pixel clock.
  initial CLOCK_25 = 1'b0;
  always #20 CLOCK_25 = ~CLOCK_25;

  // Single comparison point: counts every vector and reports any miss.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [2:0] color);
    RESET    = rst;
    color_in = color;
  endtask

  // Advance one pixel and sample just after the edge.
  task automatic tick();
    @(posedge CLOCK_25);
    #1;
  endtask

  // Main sequence: reset, first line, mid-line reset, short frames, colour.
  initial begin
    int xErr, hLow, hFirstLow, hHighAgain, actLow, actFirstLow;
    int leCount, leX, fsCount, guard;
    int sFsCount, vLowCount, vFirstLowI, vLastLowI, sMaxY;
    logic [2:0] rgbLastActive, rgbRightEdge, rgbBelowEdge;

    applyStimulus(1'b1, 3'b000);
    tick();
    tick();
    checkOutput("resetX", 32'(x), 0);
    checkOutput("resetY", 32'(y), 0);
    checkOutput("resetActive", 32'(active), 0);
    checkOutput("resetFrameStart", 32'(frameStart), 0);
    checkOutput("resetLineEnd", 32'(lineEnd), 0);
    checkOutput("resetHsync", 32'(hsync), 1);
    checkOutput("resetVsync", 32'(vsync), 1);
    checkOutput("resetRgb", 32'(rgb), 0);

    applyStimulus(1'b0, 3'b111);
    tick();
    checkOutput("firstX", 32'(x), 0);
    checkOutput("firstY", 32'(y), 0);
    checkOutput("firstActive", 32'(active), 1);
    checkOutput("firstFrameStart", 32'(frameStart), 1);
`ifndef VGA_OUT_REG_EN
    checkOutput("firstRgb", 32'(rgb), 7);
`endif

    // Observe the whole first line.
    xErr = 0; hLow = 0; hFirstLow = -1; hHighAgain = -1;
    actLow = 0; actFirstLow = -1; leCount = 0; leX = -1; fsCount = 0;
    for (int i = 0; i < 800; i++) begin
      if (int'(x) != i) xErr++;
      if (hsync == 1'b0) begin
        hLow++;
        if (hFirstLow < 0) hFirstLow = i;
      end else if (hFirstLow >= 0 && hHighAgain < 0) begin
        hHighAgain = i;
      end
      if (!active) begin
        actLow++;
        if (actFirstLow < 0) actFirstLow = i;
      end
      if (lineEnd) begin
        leCount++;
        leX = int'(x);
      end
      if (frameStart) fsCount++;
      tick();
    end
    checkOutput("xSequence", xErr, 0);
    checkOutput("hsyncLowCount", hLow, 96);
    checkOutput("hsyncFirstLow", hFirstLow, 656 + PIN_LAT);
    checkOutput("hsyncHighAgain", hHighAgain, 752 + PIN_LAT);
    checkOutput("activeLowCount", actLow, 160);
    checkOutput("activeFirstLow", actFirstLow, 640);
    checkOutput("lineEndCount", leCount, 1);
    checkOutput("lineEndX", leX, 799);
    checkOutput("lineFrameStarts", fsCount, 1);
    checkOutput("line1X", 32'(x), 0);
    checkOutput("line1Y", 32'(y), 1);
    checkOutput("line1FrameStart", 32'(frameStart), 0);

    // Reset inside the hsync pulse.
    guard = 0;
    while (int'(x) != 700 && guard < 2000) begin
      tick();
      guard++;
    end
    checkOutput("reachX700", 32'(x), 700);
    checkOutput("hsyncAtX700", 32'(hsync), 0);
    applyStimulus(1'b1, 3'b111);
    tick();
    checkOutput("midResetHsync", 32'(hsync), 1);
    checkOutput("midResetX", 32'(x), 0);
    checkOutput("midResetY", 32'(y), 0);
    checkOutput("midResetRgb", 32'(rgb), 0);
    checkOutput("midResetActive", 32'(active), 0);
    applyStimulus(1'b0, 3'b111);
    tick();
    checkOutput("postResetFrameStart", 32'(frameStart), 1);
    checkOutput("postResetX", 32'(x), 0);

    // Two short frames on the 8-line instance.
    sFsCount = 0; vLowCount = 0; vFirstLowI = -1; vLastLowI = -1; sMaxY = 0;
    rgbLastActive = 3'bxxx; rgbRightEdge = 3'bxxx; rgbBelowEdge = 3'bxxx;
    for (int i = 0; i < 12800; i++) begin
      if (sFrameStart) sFsCount++;
      if (int'(sY) > sMaxY) sMaxY = int'(sY);
      if (i < 6400 && sVsync == 1'b0) begin
        vLowCount++;
        if (vFirstLowI < 0) vFirstLowI = i;
        vLastLowI = i;
      end
      if (int'(sX) == 639 + PIN_LAT && int'(sY) == 3) rgbLastActive = sRgb;
      if (int'(sX) == 640 + PIN_LAT && int'(sY) == 0) rgbRightEdge = sRgb;
      if (int'(sX) == PIN_LAT && int'(sY) == 4) rgbBelowEdge = sRgb;
      tick();
    end
    checkOutput("smallFrameStarts", sFsCount, 2);
    checkOutput("smallMaxY", sMaxY, 7);
    checkOutput("vsyncLowCount", vLowCount, 1600);
    checkOutput("vsyncFirstLow", vFirstLowI, 4000 + PIN_LAT);
    checkOutput("vsyncLastLow", vLastLowI, 5599 + PIN_LAT);
    checkOutput("rgbLastActive", 32'(rgbLastActive), 7);
    checkOutput("rgbRightEdge", 32'(rgbRightEdge), 0);
    checkOutput("rgbBelowEdge", 32'(rgbBelowEdge), 0);

    // Colour change at x=10 on the main instance.
    applyStimulus(1'b0, 3'b000);
    guard = 0;
    while (int'(x) != 10 && guard < 2000) begin
      tick();
      guard++;
    end
    checkOutput("reachX10", 32'(x), 10);
    checkOutput("rgbBeforeToggle", 32'(rgb), 0);
    applyStimulus(1'b0, 3'b101);
    #1;
`ifndef VGA_OUT_REG_EN
    checkOutput("rgbAtToggle", 32'(rgb), 5);
`endif
    tick();
    checkOutput("toggleNextX", 32'(x), 11);
    checkOutput("rgbAfterToggle", 32'(rgb), 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/vga_timing_out.md
Name: vga_timing_out

Overview:
- Timing and pin-output stage directly around img_generator.
- Generates the 640x480@60 raster from the 25 MHz pixel clock and drives pixel coordinates x/y into img_generator.
- Takes img_generator's 3-bit colour back, blanks it outside the active area, and drives it to the VGA pins together with hsync/vsync.
- Only block that owns frame timing; the game logic can use frame_start as its per-frame tick.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels); line total 800
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines); frame total 525
- SYNC_ACTIVE, 0, logic level of an asserted sync pulse (0 = active-low)

Ports:
- CLOCK_25  in  1  pixel clock, single clock domain
- RESET  in  1  synchronous, active-high reset
- color_in  in  3  pixel colour from img_generator for the current x/y
- x  out  12  current horizontal pixel position, 0..799
- y  out  12  current line, 0..524
- active  out  1  high when x<H_ACTIVE and y<V_ACTIVE
- frame_start  out  1  one-cycle pulse at x=0,y=0
- line_end  out  1  one-cycle pulse at x=799
- hsync  out  1  horizontal sync pin
- vsync  out  1  vertical sync pin
- rgb  out  3  colour pins {r,g,b}

Behaviour:
- h counter 0..H_TOTAL-1, increments every clock. On wrap to 0 the v counter increments. v wraps 524->0 in the same cycle h wraps 799->0.
- x, y, active, frame_start, line_end are registered and mutually aligned: in the cycle x=h, every flag reflects h. Flags are computed from next-state counter values, so there is no skew.
- hsync = SYNC_ACTIVE when x in [656,751] (H_ACTIVE+H_FP .. +H_SYNC-1), else !SYNC_ACTIVE.
- vsync = SYNC_ACTIVE when y in [490,491], else !SYNC_ACTIVE. Evaluated on y only, so it changes together with y at x=0.
- rgb = active ? color_in : 3'b000, combinational. Latency 0 relative to x/y, because img_generator is combinational.
- Reset values: x=0, y=0, active=0, frame_start=0, line_end=0, hsync=vsync=!SYNC_ACTIVE, rgb=0. The internal counters are forced to h=799, v=524.
- First rising edge with RESET low presents x=0, y=0, active=1, frame_start=1.
- Reset mid-frame: takes effect at the next edge, with the same values as above. No partial sync pulse is extended; if a sync output was asserted, it deasserts at that edge.
- Widths: counters are 10 bits internally, zero-extended to 12 bits on x/y. Counters never exceed their totals; no overflow path.
- Parameter sums (H_TOTAL, V_TOTAL) are elaborated as localparams. No runtime configuration.

Optional Feature:
- Macro: VGA_OUT_REG_EN.
- Defined:
  - rgb is registered from (active ? color_in : 0).
  - hsync and vsync pass through one extra register stage, so all pins share 1-cycle latency relative to x/y.
  - Reset clears the extra stage to rgb=0 and syncs inactive.
  - x, y, active, frame_start, line_end are unchanged.
- Undefined: combinational rgb and zero-latency syncs, as described above.

Decomposition:
- Package vga_pkg: default timing constants (H_*/V_* values and totals), the SYNC_ACTIVE default, and a 3-bit color_t typedef shared with img_generator.
- One sub-module, vga_axis_counter, instantiated for h and v. Parameters: ACTIVE, FP, SYNC, BP. Inputs: enable, clear. Outputs: count, wrap, active, sync window.

Test Plan:
- Release RESET, run 800 clocks -> first cycle x=0,y=0,frame_start=1,active=1; x reaches 799 with line_end=1; next cycle x=0,y=1,frame_start=0.
- Run one full line -> hsync low for exactly 96 consecutive cycles, first low at x=656, high again at x=752; active low for x 640..799.
- Run 420000 clocks (one frame) -> vsync low only for y=490 and 491 (1600 cycles); frame_start pulses exactly once per 420000 clocks.
- Drive color_in=3'b111 constantly -> rgb=111 at (639,479), rgb=000 at (640,0) and (0,480).
- Assert RESET for 1 cycle at x=700 (inside hsync) -> next edge hsync=1, x=0, y=0, rgb=0; first cycle after release frame_start=1.
- With VGA_OUT_REG_EN: color_in toggles 000->101 at x=10 -> rgb=101 at x=11; hsync first low at x=657.
